// File: rtl/medidor_bias_pkg.sv
// medidor_bias_pkg: shared types, defaults and helpers
// for the multi-channel GARO bias meter.
package medidor_bias_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam int N_CH_DEF        = 4;
   localparam int OUT_WIDTH_DEF   = 32;
   localparam int RESOL_WIDTH_DEF = 32;

   // Clamp v to the largest value representable in w bits.
   function automatic logic [63:0] saturate(
      input logic [63:0] v,
      input int unsigned w
   );
      logic [63:0] lim;
      lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/medidor_bias_canal.sv
// medidor_bias_canal: per-channel high-sample counter.
// res already includes the sample of the current edge.
module medidor_bias_canal
   import medidor_bias_pkg::*;
#(
   parameter int RESOL_WIDTH = RESOL_WIDTH_DEF,
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 clr,
   input  logic                 inc_en,
   input  logic                 muestra,
   output logic [OUT_WIDTH-1:0] res
);

   logic [RESOL_WIDTH-1:0] cnt;
   logic [63:0]            sum;

   // Count high samples; clear has priority over increment.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc_en)
         cnt <= cnt + RESOL_WIDTH'(muestra);
   end

   assign sum = 64'(cnt) + 64'(muestra);
   assign res = OUT_WIDTH'(saturate(sum, OUT_WIDTH));

endmodule

// File: rtl/medidor_bias_multi.sv
// medidor_bias_multi: N_CH bias meter over a runtime window.
// Define MEDIDOR_BIAS_SYNC_EN to add a 2-flop input synchronizer.
module medidor_bias_multi
   import medidor_bias_pkg::*;
#(
   parameter int N_CH        = N_CH_DEF,
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
   parameter int RESOL_WIDTH = RESOL_WIDTH_DEF
) (
   input  logic                      clock,
   input  logic                      resetn,
   input  logic                      enable,
   input  logic                      start,
   input  logic [RESOL_WIDTH-1:0]    resol,
   input  logic [N_CH-1:0]           muestra,
   output logic                      busy,
   output logic                      valid,
   input  logic                      ready,
   output logic [N_CH*OUT_WIDTH-1:0] out
);

   state_t                   state, state_nx;
   logic [RESOL_WIDTH-1:0]   resol_q, cyc_cnt;
   logic [N_CH-1:0]          samp;
   logic [N_CH*OUT_WIDTH-1:0] res_all;
   logic                     req, last, load, clr;

`ifdef MEDIDOR_BIAS_SYNC_EN
   logic [N_CH-1:0] sync1, sync2;

   // Two-stage synchronizer for the asynchronous GARO samples.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= muestra;
         sync2 <= sync1;
      end
   end

   assign samp = sync2;
`else
   assign samp = muestra;
`endif

   assign req  = enable & start & (resol != '0);
   assign last = (state == MEASURE) &&
                 (cyc_cnt == resol_q - RESOL_WIDTH'(1));
   assign load = req & ((state == IDLE) |
                        ((state == DONE) & ready));
   assign clr  = load | ~enable;

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next-state logic; enable low forces IDLE from anywhere.
   always_comb begin
      state_nx = state;
      if (!enable)
         state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (req) state_nx = MEASURE;
            MEASURE: if (last) state_nx = DONE;
            DONE:    if (ready)
                        state_nx = req ? MEASURE : IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      busy  = (state == MEASURE);
      valid = (state == DONE);
   end

   // Window length latch and elapsed-sample counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         resol_q <= '0;
         cyc_cnt <= '0;
      end else begin
         if (load)
            resol_q <= resol;
         if (clr)
            cyc_cnt <= '0;
         else if (state == MEASURE)
            cyc_cnt <= cyc_cnt + RESOL_WIDTH'(1);
      end
   end

   // Result register, captured on the final sample edge only.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         out <= '0;
      else if (enable && last)
         out <= res_all;
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_canal
      medidor_bias_canal #(
         .RESOL_WIDTH(RESOL_WIDTH),
         .OUT_WIDTH  (OUT_WIDTH)
      ) u_canal (
         .clock  (clock),
         .resetn (resetn),
         .clr    (clr),
         .inc_en (state == MEASURE),
         .muestra(samp[i]),
         .res    (res_all[i*OUT_WIDTH +: OUT_WIDTH])
      );
   end

endmodule

// File: tb/tb_medidor_bias_multi.sv
// tb_medidor_bias_multi: directed + random checks of the
// multi-channel bias meter against a sample-history model.
module tb_medidor_bias_multi;

   localparam int N  = 4;
   localparam int OW = 10;
   localparam int RW = 12;
`ifdef MEDIDOR_BIAS_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic          clock = 1'b0;
   logic          resetn, enable, start, ready;
   logic          busy, valid;
   logic [RW-1:0] resol;
   logic [N-1:0]  muestra;
   logic [N*OW-1:0] out;

   int vectors = 0;
   int errs    = 0;
   int ecount  = 0;
   logic [N-1:0] hist [0:16383];

   always #5 clock = ~clock;

   // Record the sample presented at every rising edge.
   always @(posedge clock) begin
      hist[ecount] <= muestra;
      ecount       <= ecount + 1;
   end

   medidor_bias_multi #(
      .N_CH       (N),
      .OUT_WIDTH  (OW),
      .RESOL_WIDTH(RW)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .enable (enable),
      .start  (start),
      .resol  (resol),
      .muestra(muestra),
      .busy   (busy),
      .valid  (valid),
      .ready  (ready),
      .out    (out)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "timeout");
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Expected result: samples seen D edges earlier, over E1..ER.
   function automatic logic [N*OW-1:0] model(int e0, int r);
      logic [N*OW-1:0] v;
      longint          s;
      longint          lim;
      v   = '0;
      lim = (longint'(1) << OW) - 1;
      for (int c = 0; c < N; c++) begin
         s = 0;
         for (int k = 1; k <= r; k++)
            s += longint'(hist[e0 + k - D][c]);
         if (s > lim) s = lim;
         v[c*OW +: OW] = OW'(s);
      end
      return v;
   endfunction

   function automatic logic [N-1:0] pat(int mode, int k);
      logic [N-1:0] p;
      case (mode)
         0:       p = 4'b0101;
         1:       p = {2'b00, 1'b1, k[0]};
         2:       p = 4'b1111;
         default: p = N'($urandom);
      endcase
      return p;
   endfunction

   task automatic begin_window(int r, output int e0);
      @(negedge clock);
      start = 1'b1;
      resol = RW'(r);
      @(posedge clock);
      #1 e0 = ecount - 1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic run(int k0, int k1, int mode);
      for (int k = k0; k <= k1; k++) begin
         chk("busy_run", 64'(busy), 64'd1);
         muestra = pat(mode, k);
         @(negedge clock);
      end
   endtask

   task automatic finish_chk(string tag, int e0, int r,
                             output logic [N*OW-1:0] ev);
      ev = model(e0, r);
      chk({tag, "_valid"}, 64'(valid), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_out"}, 64'(out), 64'(ev));
   endtask

   task automatic consume();
      ready = 1'b1;
      @(negedge clock);
      ready = 1'b0;
   endtask

   initial begin
      int              e0;
      logic [N*OW-1:0] ev, prev;
      resetn  = 1'b0;
      enable  = 1'b1;
      start   = 1'b0;
      ready   = 1'b0;
      resol   = '0;
      muestra = '0;
      repeat (2) @(negedge clock);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_out", 64'(out), 64'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clock);

      // Constant pattern, short window, single valid cycle.
      begin_window(10, e0);
      run(1, 10, 0);
      finish_chk("t1", e0, 10, ev);
      ready = 1'b1;
      @(negedge clock);
      chk("t1_valid_drop", 64'(valid), 64'd0);
      chk("t1_idle_busy", 64'(busy), 64'd0);
      ready = 1'b0;

      // Long window, results held while consumer stalls.
      begin_window(1000, e0);
      run(1, 1000, 1);
      finish_chk("t2", e0, 1000, ev);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         chk("t2_hold_valid", 64'(valid), 64'd1);
         chk("t2_hold_out", 64'(out), 64'(ev));
      end
      ready = 1'b1;
      @(negedge clock);
      chk("t2_valid_drop", 64'(valid), 64'd0);
      ready = 1'b0;

      // Saturation boundary.
      begin_window(1023, e0);
      run(1, 1023, 2);
      finish_chk("t3a", e0, 1023, ev);
      consume();
      begin_window(1100, e0);
      run(1, 1100, 2);
      finish_chk("t3b", e0, 1100, ev);
      chk("t3b_sat", 64'(out), 64'({4{10'h3FF}}));
      consume();

      // Asynchronous reset mid-window.
      begin_window(100, e0);
      run(1, 50, 3);
      #2 resetn = 1'b0;
      #1;
      chk("t4_rst_busy", 64'(busy), 64'd0);
      chk("t4_rst_valid", 64'(valid), 64'd0);
      chk("t4_rst_out", 64'(out), 64'd0);
      muestra = '0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      begin_window(100, e0);
      run(1, 100, 3);
      finish_chk("t4_full", e0, 100, prev);
      consume();

      // Synchronous abort keeps the previous result.
      begin_window(100, e0);
      run(1, 30, 3);
      enable = 1'b0;
      @(negedge clock);
      chk("t4_abort_busy", 64'(busy), 64'd0);
      chk("t4_abort_valid", 64'(valid), 64'd0);
      chk("t4_abort_out", 64'(out), 64'(prev));
      enable = 1'b1;
      @(negedge clock);

      // Back-to-back windows with no idle cycle.
      begin_window(10, e0);
      run(1, 10, 3);
      finish_chk("t5a", e0, 10, ev);
      ready = 1'b1;
      start = 1'b1;
      resol = RW'(7);
      @(posedge clock);
      #1 e0 = ecount - 1;
      @(negedge clock);
      start = 1'b0;
      ready = 1'b0;
      chk("t5_b2b_busy", 64'(busy), 64'd1);
      chk("t5_b2b_valid", 64'(valid), 64'd0);
      run(1, 7, 3);
      finish_chk("t5b", e0, 7, ev);
      consume();

      // Zero-length request is ignored.
      start = 1'b1;
      resol = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t5_r0_busy", 64'(busy), 64'd0);
         chk("t5_r0_valid", 64'(valid), 64'd0);
      end
      start = 1'b0;

      // Input rising right after the start edge.
      muestra = '0;
      repeat (3) @(negedge clock);
      begin_window(10, e0);
      run(1, 10, 2);
      finish_chk("t6", e0, 10, ev);
      chk("t6_ch0", 64'(out[OW-1:0]), 64'(10 - D));
      consume();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errs);
      $finish;
   end

endmodule
